// File: rtl/sti_pkg.sv
// Shared definitions for the sti binary-image memory: FSM states, default
// geometry, and the addressing rules the distance-transform read side also uses.
package sti_pkg;

  localparam int DEF_IMG_W  = 128;
  localparam int DEF_IMG_H  = 128;
  localparam int DEF_PIX_W  = 8;
  localparam int DEF_ADDR_W = 10;
  localparam int WORD_BITS  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Linear word index of the word holding pixel (row, col); for a 128-wide
  // image this is {row, col[6:4]}.
  function automatic int unsigned word_idx(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned img_w);
    return row * (img_w / WORD_BITS) + col / WORD_BITS;
  endfunction

  // Bit position of a pixel inside its word: leftmost pixel lands in the MSB.
  function automatic logic [3:0] bit_idx(input logic [3:0] col_lo);
    return 4'd15 - col_lo;
  endfunction

endpackage

// File: rtl/sti_img_loader_if.sv
// Raster pixel stream into the sti loader (valid/ready handshake).
// master = pixel source, slave = loader.
interface sti_img_loader_if #(
  parameter int PIX_W = sti_pkg::DEF_PIX_W
);
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_last;
  logic             pix_ready;

  modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);
endinterface

// File: rtl/sti_word_packer.sv
// 16-bit MSB-first shift register that packs binarized pixels into sti words.
// word_next is the word including the bit being shifted in this cycle, so the
// owner can register it on the same edge the 16th pixel is accepted.
module sti_word_packer
  import sti_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        bit_in,
  input  logic [3:0]  col_lo,
  output logic [15:0] word_next,
  output logic        word_full
);

  logic [15:0] shift_reg;

  assign word_next = {shift_reg[14:0], bit_in};
  // The pixel that fills bit 0 closes the word.
  assign word_full = shift_en & (bit_idx(col_lo) == 4'd0);

  // Shift register: cleared at frame start, shifts on every accepted pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
    end else if (clear) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= word_next;
    end
  end

endmodule

// File: rtl/sti_img_loader.sv
// Writer side of the sti binary-image memory. Binarizes a raster pixel stream
// against a captured threshold, packs 16 pixels per word and writes each word
// at its linear word index; pulses done once the whole frame is stored.
// Optional build macro STI_BORDER_CLR_EN: forces the outermost image rows and
// columns to 0 before packing, giving the DT engine a guaranteed zero border.
module sti_img_loader
  import sti_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  thr,
  sti_img_loader_if.slave   pix,
  output logic              sti_wr,
  output logic [ADDR_W-1:0] sti_addr,
  output logic [15:0]       sti_do,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_t            state_reg, state_next;
  logic [PIX_W-1:0]  thr_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic              err_reg;

  logic              start_acc;
  logic              pix_acc;
  logic              col_end;
  logic              row_end;
  logic              frame_end;
  logic              pix_bit;
  logic [15:0]       word_next;
  logic              word_full;

  assign start_acc = (state_reg == IDLE) & start;
  assign pix_acc   = pix.pix_valid & pix.pix_ready;
  assign col_end   = (col_reg == COL_W'(IMG_W - 1));
  assign row_end   = (row_reg == ROW_W'(IMG_H - 1));
  assign frame_end = pix_acc & col_end & row_end;
  assign err       = err_reg;

  // Binarize the current pixel; unsigned compare against the held threshold.
  always_comb begin
    pix_bit = (pix.pix_data >= thr_reg);
`ifdef STI_BORDER_CLR_EN
    if ((col_reg == '0) || col_end || (row_reg == '0) || row_end) begin
      pix_bit = 1'b0;
    end
`endif
  end

  sti_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_acc),
    .shift_en  (pix_acc),
    .bit_in    (pix_bit),
    .col_lo    (col_reg[3:0]),
    .word_next (word_next),
    .word_full (word_full)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; the frame ends on the counter, not on pix_last.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)     state_next = LOAD;
      LOAD:    if (frame_end) state_next = FLUSH;
      FLUSH:   if (sti_wr)    state_next = FIN;
      FIN:                    state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // FSM outputs: the stream is never stalled while loading.
  always_comb begin
    pix.pix_ready = (state_reg == LOAD);
    busy          = (state_reg != IDLE);
    done          = (state_reg == FIN);
  end

  // Threshold capture, raster counters and the sticky pix_last mismatch flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thr_reg <= '0;
      col_reg <= '0;
      row_reg <= '0;
      err_reg <= 1'b0;
    end else if (start_acc) begin
      thr_reg <= thr;
      col_reg <= '0;
      row_reg <= '0;
      err_reg <= 1'b0;
    end else if (pix_acc) begin
      if (col_end) begin
        col_reg <= '0;
        row_reg <= row_end ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
      if (pix.pix_last != (col_end & row_end)) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Memory write port: one strobe the cycle after a word completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sti_wr   <= 1'b0;
      sti_addr <= '0;
      sti_do   <= '0;
    end else begin
      sti_wr <= word_full;
      if (word_full) begin
        sti_addr <= ADDR_W'(word_idx(32'(row_reg), 32'(col_reg), IMG_W));
        sti_do   <= word_next;
      end
    end
  end

endmodule

// File: tb/tb_sti_img_loader.sv
// Bench for sti_img_loader: a pixel-array model predicts every write, the
// done/busy/err behaviour and stream acceptance cycle by cycle; literal word
// values pin the model for the documented frames.
`timescale 1ns/1ps
module tb_sti_img_loader;

  localparam int W      = 128;
  localparam int H      = 128;
  localparam int NPIX   = W * H;
  localparam int NWORDS = NPIX / 16;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  thr   = 8'h00;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic        busy, done, err;

  sti_img_loader_if #(.PIX_W(8)) pix_if ();

  sti_img_loader #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .thr      (thr),
    .pix      (pix_if),
    .sti_wr   (sti_wr),
    .sti_addr (sti_addr),
    .sti_do   (sti_do),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Frame image currently being streamed.
  logic [7:0] img [NPIX];

  // Model state.
  int         phase = 0;   // 0 idle, 1 loading, 2 final write, 3 done pulse
  int         pcnt  = 0;
  logic [7:0] thr_m = 8'h00;
  bit         exp_wr = 1'b0;
  int         exp_addr = 0;
  logic [15:0] exp_do = 16'h0;
  bit         err_m = 1'b0;
  int         wr_count = 0, done_count = 0, cyc = 0;
  int         acc16_cyc = 0, wr0_cyc = 0, last_wr_addr = -1;
  int         wr_mem [NWORDS];

  function automatic bit model_bit(input int k);
    int r, c;
    bit b;
    r = k / W;
    c = k % W;
    b = (img[k] >= thr_m);
`ifdef STI_BORDER_CLR_EN
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [15:0] model_word(input int w);
    logic [15:0] v;
    v = 16'h0;
    for (int i = 0; i < 16; i++) v[15 - i] = model_bit(w * 16 + i);
    return v;
  endfunction

  // Compare process: outputs checked every cycle on the falling edge, then
  // the model advances using the inputs that the next rising edge will see.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      phase  = 0;
      pcnt   = 0;
      exp_wr = 1'b0;
      err_m  = 1'b0;
    end else begin
      chk("pix_ready", 32'(pix_if.pix_ready), 32'(phase == 1));
      chk("busy",      32'(busy),             32'(phase != 0));
      chk("done",      32'(done),             32'(phase == 3));
      chk("err",       32'(err),              32'(err_m));
      chk("sti_wr",    32'(sti_wr),           32'(exp_wr));
      if (sti_wr && exp_wr) begin
        chk("sti_addr", 32'(sti_addr), 32'(exp_addr));
        chk("sti_do",   32'(sti_do),   32'(exp_do));
      end
      if (sti_wr) begin
        wr_count++;
        wr_mem[sti_addr] = 32'(sti_do);
        last_wr_addr = 32'(sti_addr);
        if (sti_addr == 10'd0) wr0_cyc = cyc;
      end
      if (done) done_count++;
      exp_wr = 1'b0;
      case (phase)
        0: if (start) begin
             phase = 1;
             thr_m = thr;
             pcnt  = 0;
             err_m = 1'b0;
           end
        1: if (pix_if.pix_valid) begin
             if (pix_if.pix_last != (pcnt == NPIX - 1)) err_m = 1'b1;
             if (pcnt % 16 == 15) begin
               exp_wr   = 1'b1;
               exp_addr = pcnt / 16;
               exp_do   = model_word(pcnt / 16);
             end
             if (pcnt == 15) acc16_cyc = cyc;
             pcnt++;
             if (pcnt == NPIX) phase = 2;
           end
        2: phase = 3;
        default: phase = 0;
      endcase
    end
  end

  task automatic fill_const(input logic [7:0] v);
    for (int k = 0; k < NPIX; k++) img[k] = v;
  endtask

  // Row 0 alternates 0x00/0xFF from col 0; other rows a fixed arithmetic pattern.
  task automatic fill_pattern();
    for (int k = 0; k < NPIX; k++) begin
      if (k < W) img[k] = (k % 2 == 0) ? 8'h00 : 8'hFF;
      else img[k] = 8'((k / W) * 7 + (k % W) * 13);
    end
  endtask

  task automatic pulse_start(input logic [7:0] t);
    thr   = t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pixels(input int npix, input bit gaps, input int last_at,
                             input bit last_end, input int thr_chg_at, input int start_at);
    for (int k = 0; k < npix; k++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
          pix_if.pix_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      pix_if.pix_valid = 1'b1;
      pix_if.pix_data  = img[k];
      pix_if.pix_last  = (k == last_at) || (last_end && k == NPIX - 1);
      start = (k == start_at);
      if (k == thr_chg_at) thr = 8'hF0;
      @(posedge clk); #1;
    end
    pix_if.pix_valid = 1'b0;
    pix_if.pix_last  = 1'b0;
    start            = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int w0, d0;

  initial begin
    pix_if.pix_valid = 1'b0;
    pix_if.pix_data  = 8'h00;
    pix_if.pix_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst pix_ready", 32'(pix_if.pix_ready), 32'd0);
    chk("rst sti_wr",    32'(sti_wr),   32'd0);
    chk("rst sti_addr",  32'(sti_addr), 32'd0);
    chk("rst sti_do",    32'(sti_do),   32'd0);
    chk("rst busy",      32'(busy),     32'd0);
    chk("rst done",      32'(done),     32'd0);
    chk("rst err",       32'(err),      32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Frame of all 0xFF, threshold 0x80.
    fill_const(8'hFF);
    w0 = wr_count; d0 = done_count;
    pulse_start(8'h80);
    send_pixels(NPIX, 1'b0, -1, 1'b1, -1, -1);
    repeat (5) @(posedge clk);
    #1;
    $display("frame ff: writes=%0d done=%0d err=%0d", wr_count - w0, done_count - d0, err);
    chk("t1 writes", 32'(wr_count - w0), 32'd1024);
    chk("t1 done",   32'(done_count - d0), 32'd1);
    chk("t1 err",    32'(err), 32'd0);
`ifdef STI_BORDER_CLR_EN
    chk("t1 word0",    32'(wr_mem[0]),    32'h0000);
    chk("t1 word8",    32'(wr_mem[8]),    32'h7FFF);
    chk("t1 word15",   32'(wr_mem[15]),   32'hFFFE);
    chk("t1 word1023", 32'(wr_mem[1023]), 32'h0000);
`else
    chk("t1 word0",    32'(wr_mem[0]),    32'hFFFF);
    chk("t1 word8",    32'(wr_mem[8]),    32'hFFFF);
    chk("t1 word15",   32'(wr_mem[15]),   32'hFFFF);
    chk("t1 word1023", 32'(wr_mem[1023]), 32'hFFFF);
`endif

    // Alternating row 0, thr 0x01, pix_last on pixel 100 and missing at the end.
    fill_pattern();
    w0 = wr_count; d0 = done_count;
    pulse_start(8'h01);
    send_pixels(NPIX, 1'b0, 100, 1'b0, -1, -1);
    repeat (5) @(posedge clk);
    #1;
    $display("frame alt/badlast: writes=%0d done=%0d err=%0d word0=%04h", wr_count - w0, done_count - d0, err, wr_mem[0]);
    chk("t2 writes",  32'(wr_count - w0), 32'd1024);
    chk("t2 done",    32'(done_count - d0), 32'd1);
    chk("t2 err",     32'(err), 32'd1);
    chk("t2 latency", 32'(wr0_cyc - acc16_cyc), 32'd1);
`ifdef STI_BORDER_CLR_EN
    chk("t2 word0", 32'(wr_mem[0]), 32'h0000);
    chk("t2 word8", 32'(wr_mem[8]), 32'h7FFF);
`else
    chk("t2 word0", 32'(wr_mem[0]), 32'h5555);
    chk("t2 word8", 32'(wr_mem[8]), 32'hFFFF);
`endif

    // Restart clears err; reset after 20 pixels discards the partial word.
    w0 = wr_count;
    pulse_start(8'h01);
    chk("t6 err cleared", 32'(err),  32'd0);
    chk("t6 busy",        32'(busy), 32'd1);
    send_pixels(20, 1'b0, -1, 1'b0, -1, -1);
    reset = 1'b0;
    #2;
    $display("reset mid-frame: writes=%0d last_addr=%0d", wr_count - w0, last_wr_addr);
    chk("t6 writes",    32'(wr_count - w0), 32'd1);
    chk("t6 addr",      32'(last_wr_addr), 32'd0);
    chk("t6 pix_ready", 32'(pix_if.pix_ready), 32'd0);
    chk("t6 sti_wr",    32'(sti_wr),   32'd0);
    chk("t6 sti_addr",  32'(sti_addr), 32'd0);
    chk("t6 sti_do",    32'(sti_do),   32'd0);
    chk("t6 busy0",     32'(busy),     32'd0);
    chk("t6 done",      32'(done),     32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Same alternating frame with random gaps, start and thr changes mid-frame.
    w0 = wr_count; d0 = done_count;
    pulse_start(8'h01);
    send_pixels(NPIX, 1'b1, -1, 1'b1, 3000, 5000);
    repeat (5) @(posedge clk);
    #1;
    $display("frame gaps: writes=%0d done=%0d err=%0d word0=%04h", wr_count - w0, done_count - d0, err, wr_mem[0]);
    chk("t4 writes",  32'(wr_count - w0), 32'd1024);
    chk("t4 done",    32'(done_count - d0), 32'd1);
    chk("t4 err",     32'(err), 32'd0);
    chk("t4 latency", 32'(wr0_cyc - acc16_cyc), 32'd1);
`ifdef STI_BORDER_CLR_EN
    chk("t4 word0", 32'(wr_mem[0]), 32'h0000);
    chk("t4 word8", 32'(wr_mem[8]), 32'h7FFF);
`else
    chk("t4 word0", 32'(wr_mem[0]), 32'h5555);
    chk("t4 word8", 32'(wr_mem[8]), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
